count_bcd_converter: RTL
========================

Name: count_bcd_converter

Overview:
- Downstream stage of the up/down counter: takes the binary count word and converts it to packed BCD digits for the display/readout stage.
- Sequential shift-and-add-3 (double-dabble) engine, one bit per clock; request/done handshake.
- Captures the counter output on request, so the counter keeps running during conversion.

Parameters:
- N, 8, width of binary input (matches counter width).
- DIGITS, 3, number of BCD output digits; must satisfy 10^DIGITS > 2^N (legal configs only; no runtime overflow check).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- bin_in  input  N  binary value, normally the counter's count output.
- start  input  1  conversion request, sampled on rising clk edge when idle.
- busy  output  1  high while a conversion is in progress.
- done  output  1  single-cycle pulse: bcd_out just updated with a new result.
- bcd_out  output  4*DIGITS  packed BCD result; digit 0 (units) in bits [3:0].

Behaviour:
- Reset: rst_n low at a rising edge -> state IDLE, busy=0, done=0, bcd_out=0, internal shift register and bit counter cleared. Reset has priority over every other input.
- States: IDLE, SHIFT.
- IDLE:
  - busy=0.
  - On an edge with start=1: capture bin_in into the binary part of the shift register, clear the BCD part, set bit counter to 0, go to SHIFT. busy=1 from the next cycle.
  - start=0: stay in IDLE; bcd_out holds.
- SHIFT, each edge:
  - For every 4-bit BCD digit >= 5, add 3 (all digits evaluated in parallel on pre-shift values).
  - Shift the combined {BCD, binary} register left by 1.
  - Increment the bit counter.
- Completion: on the edge performing shift number N (counter == N-1), load the post-shift BCD part into bcd_out, assert done, deassert busy, return to IDLE.
- Latency: start sampled at edge E0; shifts at E1..EN; done=1 and bcd_out valid in the cycle after EN. Exactly N cycles from the accepting edge to the done cycle.
- done: high exactly one cycle, then returns to 0.
- bcd_out: changes only at completion or reset; holds the last result otherwise.
- start while busy: ignored, not queued; the in-flight conversion is unaffected.
- start in the done cycle: state is already IDLE, so it is accepted. Back-to-back throughput is one result per N+1 cycles.
- bin_in changes during SHIFT: no effect; the captured value is converted.
- Reset mid-conversion: aborts immediately. No done pulse; bcd_out goes to 0.
- Width rules:
  - Bit counter sized to hold N-1.
  - Add-3 is performed within each 4-bit digit (no carry between digits needed, since the digit is at most 9 before shift).
  - Bits shifted out of the top BCD digit are discarded; this is unreachable for legal DIGITS.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Reset: hold rst_n=0 for 3 edges with start=1, bin_in=8'hFF -> busy=0, done=0, bcd_out=12'h000 throughout. Release reset -> still idle until the next start edge.
- Basic: bin_in=8'd0, start pulse -> done exactly 8 cycles after the accepting edge, bcd_out=12'h000. Then bin_in=8'd255 -> bcd_out=12'h255. Then bin_in=8'd99 -> 12'h099. Then bin_in=8'd100 -> 12'h100.
- Input stability: start with bin_in=8'd137, change bin_in to 8'd42 on the next cycle -> bcd_out=12'h137. Start held high during busy -> no restart, exactly one done pulse.
- Back-to-back: start high continuously with bin_in=8'd58, then 8'd201 -> done pulses every 9 cycles; results 12'h058, then 12'h201. busy is low only in the done cycles.
- Reset mid-conversion: start with bin_in=8'd200, assert rst_n=0 after 4 shift edges -> no done pulse, bcd_out=12'h000. Then convert 8'd7 -> 12'h007.
- Integration with counter: counter counting down from 0 (wraps to 255), start pulsed every 16 cycles -> each bcd_out equals the decimal of the count sampled at the accepting edge. Exhaustive sweep 0..255 against a reference model matches.

Source files
------------

// File: rtl/count_bcd_converter.sv
// rtl/count_bcd_converter.sv - sequential double-dabble binary to packed BCD converter
// Captures bin_in on an idle start edge, shifts one bit per clock, pulses done with the result.
module count_bcd_converter #(
  parameter int N      = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0]          bin_in,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = 4 * DIGITS + N;
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t              state_q, state_d;
  logic [SW-1:0]       shreg_q, shreg_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;

  logic [SW-1:0]       adjusted;
  logic [SW-1:0]       shifted;

  // Add-3 is applied per digit on pre-shift values; digits never exceed 9 so no inter-digit carry.
  always_comb begin
    adjusted = shreg_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (shreg_q[N + 4*i +: 4] >= 4'd5) begin
        adjusted[N + 4*i +: 4] = shreg_q[N + 4*i +: 4] + 4'd3;
      end
    end
    shifted = adjusted << 1;
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bcd_d   = bcd_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d = {{(4*DIGITS){1'b0}}, bin_in};
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shreg_d = shifted;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          bcd_d   = shifted[SW-1 -: 4*DIGITS];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;

endmodule
